control_barrera: RTL and testbench

Controller for the single shared barrier of the parking lot. It latches entry and exit requests and arbitrates between them round-robin. Entry is blocked while the lot is full and exit is blocked while it is empty. For each granted request it opens the barrier, waits for the matching passage pulse from the sensor decoder or a timeout, then holds the barrier open for a fixed close delay. It sits beside `estacionamiento_top`, taking that block's occupancy `count` and its entry/exit event pulses, and drives the barrier actuator.

---
 rtl/estacionamiento_pkg.sv | 30 +++
 rtl/control_barrera_temporizador.sv | 48 ++++
 rtl/control_barrera.sv | 178 +++++++++++++++++
 tb/tb_control_barrera.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/estacionamiento_pkg.sv
// ============================================================================
// Module  : estacionamiento_pkg
// Purpose : Shared definitions for the parking-lot blocks: barrier FSM state
//           encoding, service direction constants and default count width.
// Ports   : none (package)
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package estacionamiento_pkg;

    // Barrier controller states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Direction of the most recently granted request.
    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Default occupancy counter width.
    localparam int CW_DEFAULT = 3;

endpackage : estacionamiento_pkg

`default_nettype wire

// File: rtl/control_barrera_temporizador.sv
// ============================================================================
// Module  : temporizador
// Purpose : Loadable, clearable, saturating up-counter with a runtime limit
//           compare. Shared by the passage-wait and close-delay phases.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           clr_i           - clear count to zero (priority over load)
//           load_i/load_val_i - load an arbitrary start value
//           en_i            - count enable
//           limit_i         - compare value for done_o
//           done_o          - high while count equals limit_i
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module temporizador #(
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          en_i,
    input  logic [TW-1:0] limit_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '1)) begin
            // Saturate at all-ones so a long idle period never wraps.
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == limit_i);

endmodule : temporizador

`default_nettype wire

// File: rtl/control_barrera.sv
// ============================================================================
// Module  : control_barrera
// Purpose : Shared parking barrier controller. Latches entry/exit requests,
//           arbitrates round-robin, blocks entry when full and exit when
//           empty, opens the gate, waits for a passage or timeout, then holds
//           the gate open for a fixed close delay.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           req_in / req_out      - request pulses (ticket / card reader)
//           car_entered/car_exited- passage pulses from the sensor decoder
//           count                 - current occupancy
//           gate_open             - barrier actuator, 1 = open
//           grant_in / grant_out  - entry / exit being served
//           full                  - registered count >= CAPACITY
//           timeout               - one-cycle pulse on passage-wait expiry
//           n_served, n_timeouts  - saturating statistics (optional)
// Config  : CONTROL_BARRERA_STATS_EN adds the n_served/n_timeouts outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module control_barrera
    import estacionamiento_pkg::*;
#(
    parameter int CAPACITY   = 7,
    parameter int CW         = CW_DEFAULT,
    parameter int WAIT_TICKS = 50,
    parameter int HOLD_TICKS = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_in,
    input  logic          req_out,
    input  logic          car_entered,
    input  logic          car_exited,
    input  logic [CW-1:0] count,
    output logic          gate_open,
    output logic          grant_in,
    output logic          grant_out,
    output logic          full,
    output logic          timeout
`ifdef CONTROL_BARRERA_STATS_EN
    ,
    output logic [7:0]    n_served,
    output logic [7:0]    n_timeouts
`endif
);

    localparam int TW = $clog2((WAIT_TICKS > HOLD_TICKS) ? WAIT_TICKS : HOLD_TICKS);

    state_t  state_q, state_d;
    logic    pend_in_q, pend_in_d;
    logic    pend_out_q, pend_out_d;
    logic    last_dir_q, last_dir_d;
    logic    timeout_d;
    logic    served_evt;
    logic    elig_in, elig_out;
    logic    tmr_done;
    logic [TW-1:0] tmr_limit;

    // Timer restarts on every state change; it serves both the passage wait
    // and the close delay, so only the compare limit differs.
    temporizador #(
        .TW (TW)
    ) u_tmr (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_d != state_q),
        .load_i     (1'b0),
        .load_val_i ({TW{1'b0}}),
        .en_i       (1'b1),
        .limit_i    (tmr_limit),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        pend_in_d  = pend_in_q  | req_in;
        pend_out_d = pend_out_q | req_out;
        last_dir_d = last_dir_q;
        timeout_d  = 1'b0;
        served_evt = 1'b0;
        tmr_limit  = (state_q == HOLD) ? TW'(HOLD_TICKS - 1) : TW'(WAIT_TICKS - 1);

        // Eligibility looks at the live pulse too so a request in IDLE is
        // granted on the same edge that samples it.
        elig_in  = (pend_in_q  | req_in)  & ~full;
        elig_out = (pend_out_q | req_out) & (count != '0);

        unique case (state_q)
            IDLE: begin
                if (elig_in && (!elig_out || (last_dir_q == DIR_OUT))) begin
                    state_d    = OPEN_IN;
                    pend_in_d  = 1'b0;
                    last_dir_d = DIR_IN;
                end else if (elig_out) begin
                    state_d    = OPEN_OUT;
                    pend_out_d = 1'b0;
                    last_dir_d = DIR_OUT;
                end
            end
            OPEN_IN: begin
                if (car_entered) begin
                    state_d    = HOLD;
                    served_evt = 1'b1;
                end else if (tmr_done) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                end
            end
            OPEN_OUT: begin
                if (car_exited) begin
                    state_d    = HOLD;
                    served_evt = 1'b1;
                end else if (tmr_done) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register without a decode stage after the flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_in_q  <= 1'b0;
            pend_out_q <= 1'b0;
            last_dir_q <= DIR_OUT;
            gate_open  <= 1'b0;
            grant_in   <= 1'b0;
            grant_out  <= 1'b0;
            timeout    <= 1'b0;
            full       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_in_q  <= pend_in_d;
            pend_out_q <= pend_out_d;
            last_dir_q <= last_dir_d;
            gate_open  <= (state_d != IDLE);
            grant_in   <= (state_d == OPEN_IN);
            grant_out  <= (state_d == OPEN_OUT);
            timeout    <= timeout_d;
            full       <= (count >= CW'(CAPACITY));
        end
    end

`ifdef CONTROL_BARRERA_STATS_EN
    logic [7:0] n_served_q;
    logic [7:0] n_timeouts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            n_served_q   <= 8'd0;
            n_timeouts_q <= 8'd0;
        end else begin
            if (served_evt && (n_served_q != 8'hFF)) begin
                n_served_q <= n_served_q + 8'd1;
            end
            if (timeout_d && (n_timeouts_q != 8'hFF)) begin
                n_timeouts_q <= n_timeouts_q + 8'd1;
            end
        end
    end

    assign n_served   = n_served_q;
    assign n_timeouts = n_timeouts_q;
`endif

endmodule : control_barrera

`default_nettype wire

// File: tb/tb_control_barrera.sv
// ============================================================================
// Module  : tb_control_barrera
// Purpose : Directed self-checking bench for control_barrera. Inputs change
//           1 time unit after a rising edge; outputs are sampled there too.
// Config  : CONTROL_BARRERA_STATS_EN enables the statistics scenario.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_barrera;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_in, req_out, car_entered, car_exited;
    logic [2:0] count;
    logic       gate_open, grant_in, grant_out, full, timeout;
`ifdef CONTROL_BARRERA_STATS_EN
    logic [7:0] n_served, n_timeouts;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    control_barrera dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .req_out     (req_out),
        .car_entered (car_entered),
        .car_exited  (car_exited),
        .count       (count),
        .gate_open   (gate_open),
        .grant_in    (grant_in),
        .grant_out   (grant_out),
        .full        (full),
        .timeout     (timeout)
`ifdef CONTROL_BARRERA_STATS_EN
        ,
        .n_served    (n_served),
        .n_timeouts  (n_timeouts)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; count = 3'd7;
        step();
        checks++;
        if ({gate_open, grant_in, grant_out, timeout, full} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {gate_open, grant_in, grant_out, timeout, full});
        end
        reset = 1'b0;
        step();
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL full_set: got %b expected 1", full);
        end
        count = 3'd0;
        step();
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL full_clear: got %b expected 0", full);
        end
    endtask

    task automatic test_entry();
        count = 3'd0;
        req_in = 1'b1; step(); req_in = 1'b0;
        checks++;
        if ({gate_open, grant_in, grant_out} !== 3'b110) begin
            errors++;
            $display("FAIL entry_grant: got %b expected 110", {gate_open, grant_in, grant_out});
        end
        step(); step();
        car_entered = 1'b1; step(); car_entered = 1'b0;
        checks++;
        if ({gate_open, grant_in} !== 2'b10) begin
            errors++;
            $display("FAIL entry_passage: got %b expected 10", {gate_open, grant_in});
        end
        for (int i = 1; i < 10; i++) begin
            step();
            checks++;
            if (gate_open !== 1'b1) begin
                errors++;
                $display("FAIL entry_hold cycle %0d: gate_open got %b expected 1", i, gate_open);
            end
        end
        step();
        checks++;
        if (gate_open !== 1'b0) begin
            errors++;
            $display("FAIL entry_close: gate_open got %b expected 0", gate_open);
        end
    endtask

    task automatic test_empty_block();
        count = 3'd0;
        req_out = 1'b1; step(); req_out = 1'b0;
        step(); step();
        checks++;
        if ({gate_open, grant_out} !== 2'b00) begin
            errors++;
            $display("FAIL empty_exit_blocked: got %b expected 00", {gate_open, grant_out});
        end
        // Drop the blocked exit request so later scenarios start clean.
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    task automatic test_tie();
        count = 3'd3;
        step();
        req_in = 1'b1; req_out = 1'b1; step(); req_in = 1'b0; req_out = 1'b0;
        checks++;
        if ({grant_in, grant_out} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first: got %b expected 10", {grant_in, grant_out});
        end
        car_entered = 1'b1; step(); car_entered = 1'b0;
        repeat (10) step();
        checks++;
        if ({gate_open, grant_out} !== 2'b00) begin
            errors++;
            $display("FAIL tie_idle_gap: got %b expected 00", {gate_open, grant_out});
        end
        step();
        checks++;
        if ({gate_open, grant_out} !== 2'b11) begin
            errors++;
            $display("FAIL tie_second: got %b expected 11", {gate_open, grant_out});
        end
        car_entered = 1'b1; step(); car_entered = 1'b0;
        checks++;
        if (grant_out !== 1'b1) begin
            errors++;
            $display("FAIL tie_wrong_passage_ignored: grant_out got %b expected 1", grant_out);
        end
        car_exited = 1'b1; step(); car_exited = 1'b0;
        checks++;
        if ({gate_open, grant_out} !== 2'b10) begin
            errors++;
            $display("FAIL tie_exit_passage: got %b expected 10", {gate_open, grant_out});
        end
        repeat (10) step();
        checks++;
        if (gate_open !== 1'b0) begin
            errors++;
            $display("FAIL tie_close: gate_open got %b expected 0", gate_open);
        end
    endtask

    task automatic test_full();
        count = 3'd7;
        step();
        req_in = 1'b1; step(); req_in = 1'b0;
        repeat (3) step();
        checks++;
        if ({gate_open, grant_in} !== 2'b00) begin
            errors++;
            $display("FAIL full_entry_blocked: got %b expected 00", {gate_open, grant_in});
        end
        req_out = 1'b1; step(); req_out = 1'b0;
        checks++;
        if ({grant_in, grant_out} !== 2'b01) begin
            errors++;
            $display("FAIL full_exit_grant: got %b expected 01", {grant_in, grant_out});
        end
        car_exited = 1'b1; count = 3'd6; step(); car_exited = 1'b0;
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL full_after_exit: got %b expected 0", full);
        end
        repeat (10) step();
        step();
        checks++;
        if ({gate_open, grant_in} !== 2'b11) begin
            errors++;
            $display("FAIL full_pending_entry: got %b expected 11", {gate_open, grant_in});
        end
        car_entered = 1'b1; count = 3'd7; step(); car_entered = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_timeout();
        count = 3'd2;
        step();
        req_out = 1'b1; step(); req_out = 1'b0;
        checks++;
        if ({gate_open, grant_out, timeout} !== 3'b110) begin
            errors++;
            $display("FAIL timeout_grant: got %b expected 110", {gate_open, grant_out, timeout});
        end
        for (int i = 1; i < 50; i++) begin
            step();
            checks++;
            if ({grant_out, timeout} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: got %b expected 10", i, {grant_out, timeout});
            end
        end
        step();
        checks++;
        if ({gate_open, grant_out, timeout} !== 3'b101) begin
            errors++;
            $display("FAIL timeout_pulse: got %b expected 101", {gate_open, grant_out, timeout});
        end
        for (int i = 1; i < 10; i++) begin
            step();
            checks++;
            if ({gate_open, timeout} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_hold cycle %0d: got %b expected 10", i, {gate_open, timeout});
            end
        end
        step();
        checks++;
        if (gate_open !== 1'b0) begin
            errors++;
            $display("FAIL timeout_close: gate_open got %b expected 0", gate_open);
        end
    endtask

    task automatic test_reset_mid();
        count = 3'd3;
        step();
        req_in = 1'b1; step(); req_in = 1'b0;
        req_out = 1'b1; step(); req_out = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if ({gate_open, grant_in, grant_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 000", {gate_open, grant_in, grant_out});
        end
        repeat (3) step();
        checks++;
        if (gate_open !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pending_dropped: gate_open got %b expected 0", gate_open);
        end
    endtask

    task automatic test_back_to_back();
        count = 3'd3;
        req_in = 1'b1; step(); req_in = 1'b0;
        car_entered = 1'b1; req_in = 1'b1; step(); car_entered = 1'b0; req_in = 1'b0;
        checks++;
        if ({gate_open, grant_in} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_passage: got %b expected 10", {gate_open, grant_in});
        end
        repeat (10) step();
        checks++;
        if (gate_open !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: gate_open got %b expected 0", gate_open);
        end
        step();
        checks++;
        if ({gate_open, grant_in} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_regrant: got %b expected 11", {gate_open, grant_in});
        end
        car_entered = 1'b1; step(); car_entered = 1'b0;
        repeat (10) step();
    endtask

`ifdef CONTROL_BARRERA_STATS_EN
    task automatic test_stats();
        reset = 1'b1; step(); reset = 1'b0;
        count = 3'd3;
        req_in = 1'b1; step(); req_in = 1'b0;
        car_entered = 1'b1; step(); car_entered = 1'b0;
        repeat (10) step();
        req_out = 1'b1; step(); req_out = 1'b0;
        car_exited = 1'b1; step(); car_exited = 1'b0;
        repeat (10) step();
        req_in = 1'b1; step(); req_in = 1'b0;
        repeat (50) step();
        repeat (10) step();
        checks++;
        if (n_served !== 8'd2) begin
            errors++;
            $display("FAIL stats_served: got %0d expected 2", n_served);
        end
        checks++;
        if (n_timeouts !== 8'd1) begin
            errors++;
            $display("FAIL stats_timeouts: got %0d expected 1", n_timeouts);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; req_in = 1'b0; req_out = 1'b0;
        car_entered = 1'b0; car_exited = 1'b0; count = 3'd0;
        step();
        test_reset();
        test_entry();
        test_empty_block();
        test_tie();
        test_full();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef CONTROL_BARRERA_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_control_barrera

`default_nettype wire
